// File: rtl/dmem_io_responder.sv
// Data-memory responder for the core: word RAM plus an I/O page holding a
// transmit FIFO, a one-entry receive holding register and a cycle counter.
module dmem_io_responder #(
  parameter int RAM_AW = 7,
  parameter int TXF_AW = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] dmemaddr,
  input  logic [15:0] dmemwdata,
  input  logic        dmemwrite,
  input  logic        dmemread,
  output logic [15:0] dmemrdata,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int RAM_WORDS = 1 << RAM_AW;
  localparam int TXF_WORDS = 1 << TXF_AW;
  localparam logic [TXF_AW:0] TXF_DEPTH = (TXF_AW + 1)'(TXF_WORDS);

  localparam logic [6:0] REG_TXDATA = 7'd0;
  localparam logic [6:0] REG_STATUS = 7'd1;
  localparam logic [6:0] REG_RXDATA = 7'd2;
  localparam logic [6:0] REG_CYCLES = 7'd3;

  logic [15:0]       ram [RAM_WORDS];
  logic [15:0]       txf_mem [TXF_WORDS];
  logic [TXF_AW-1:0] tx_rdptr, tx_wrptr;
  logic [TXF_AW:0]   tx_count;
  logic              ovf, rxfull;
  logic [15:0]       rx_hold, cycles;

  logic              io;
  logic [6:0]        reg_sel;
  logic [RAM_AW-1:0] ram_idx;
  logic              unused_addr_lsb;
  logic              txfull, txempty;
  logic              tx_pop, tx_push_req, tx_push;
  logic              rx_capture, rx_clear;
  logic              wr_status, wr_cycles;

  assign io              = (dmemaddr[15:8] == 8'hFF);
  assign reg_sel         = dmemaddr[7:1];
  assign ram_idx         = dmemaddr[RAM_AW:1];
  assign unused_addr_lsb = dmemaddr[0];

  assign txfull   = (tx_count == TXF_DEPTH);
  assign txempty  = (tx_count == '0);
  assign tx_valid = ~txempty;
  assign tx_data  = txf_mem[tx_rdptr];
  assign rx_ready = ~rxfull;

  assign tx_pop      = tx_valid & tx_ready;
  assign tx_push_req = dmemwrite & io & (reg_sel == REG_TXDATA);
  // A full FIFO still takes a push when its head leaves in the same cycle.
  assign tx_push     = tx_push_req & (~txfull | tx_pop);
  assign wr_status   = dmemwrite & io & (reg_sel == REG_STATUS);
  assign wr_cycles   = dmemwrite & io & (reg_sel == REG_CYCLES);
  assign rx_capture  = rx_valid & rx_ready;
  assign rx_clear    = dmemread & io & (reg_sel == REG_RXDATA) & rxfull;

  always_ff @(posedge clock) begin
    if (dmemwrite && !io) ram[ram_idx] <= dmemwdata;
  end

  always_ff @(posedge clock) begin
    if (tx_push) txf_mem[tx_wrptr] <= dmemwdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_rdptr <= '0;
      tx_wrptr <= '0;
      tx_count <= '0;
      ovf      <= 1'b0;
      rxfull   <= 1'b0;
      rx_hold  <= '0;
      cycles   <= '0;
    end else begin
      if (tx_pop)  tx_rdptr <= tx_rdptr + 1'b1;
      if (tx_push) tx_wrptr <= tx_wrptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase

      if (tx_push_req && !tx_push)     ovf <= 1'b1;
      else if (wr_status && dmemwdata[3]) ovf <= 1'b0;

      if (rx_capture) begin
        rx_hold <= rx_data;
        rxfull  <= 1'b1;
      end else if (rx_clear) begin
        rxfull  <= 1'b0;
      end

      if (wr_cycles) cycles <= dmemwdata;
      else           cycles <= cycles + 16'd1;
    end
  end

  // Combinational read path: reflects pre-edge state, so a same-cycle write
  // is seen only on the following cycle.
  always_comb begin
    dmemrdata = '0;
    if (dmemread) begin
      if (!io) begin
        dmemrdata = ram[ram_idx];
      end else begin
        case (reg_sel)
          REG_STATUS: dmemrdata = {12'b0, ovf, txfull, txempty, rxfull};
          REG_RXDATA: dmemrdata = rxfull ? rx_hold : 16'h0000;
          REG_CYCLES: dmemrdata = cycles;
          default:    dmemrdata = '0;
        endcase
      end
    end
  end

endmodule
